// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit arbiter
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACC  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } arb_state_t;

    localparam logic [15:0] TIMEOUT_CYC_DEFAULT = 16'd50000;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin winner select, searching from ptr+1 cyclically
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      winner_idx
);

    int          cand;
    logic [IW-1:0] cand_idx;
    logic        found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        // The last granted index (ptr) is visited last, so it has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (!found && req[cand_idx]) begin
                found              = 1'b1;
                winner[cand_idx]   = 1'b1;
                winner_idx         = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART byte transmitter
// Optional timeout/err logic enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_idle,
    output logic                 busy
`ifdef UART_TX_ARB_TIMEOUT_EN
    ,
    output logic                 err
`endif
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (TIMEOUT_CYC == 16'd0) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be nonzero");
    end

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        ptr_nxt;
    logic [IW-1:0]        gnt_idx;
    logic [IW-1:0]        gnt_idx_nxt;
    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [NUM_REQ-1:0]   ack_nxt;
    logic [7:0]           tx_data_nxt;
    logic                 tx_start_nxt;
    logic                 timeout_hit;
    logic [7:0]           req_byte [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign req_byte[i] = req_data[8*i +: 8];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (|req && tx_idle) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                state_nxt = ST_WAIT_ACC;
            end
            ST_WAIT_ACC: begin
                if (!tx_idle) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_idle || timeout_hit) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so tx_start follows
    // the START cycle and ack coincides with the RELEASE cycle.
    always_comb begin
        grant_nxt    = grant;
        gnt_idx_nxt  = gnt_idx;
        tx_data_nxt  = tx_data;
        ptr_nxt      = ptr;
        tx_start_nxt = 1'b0;
        ack_nxt      = '0;
        case (state)
            ST_IDLE: begin
                if (state_nxt == ST_START) begin
                    grant_nxt   = pick_onehot;
                    gnt_idx_nxt = pick_idx;
                    tx_data_nxt = req_byte[pick_idx];
                end
            end
            ST_START: begin
                tx_start_nxt = 1'b1;
            end
            ST_WAIT_DONE: begin
                if (tx_idle) begin
                    ack_nxt = grant;
                end
            end
            ST_RELEASE: begin
                grant_nxt = '0;
                ptr_nxt   = gnt_idx;
            end
            default: begin
                grant_nxt = grant;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant    <= '0;
            gnt_idx  <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            ptr      <= IW'(NUM_REQ - 1);
        end else begin
            grant    <= grant_nxt;
            gnt_idx  <= gnt_idx_nxt;
            ack      <= ack_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            ptr      <= ptr_nxt;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        in_wait;

    assign in_wait = (state == ST_WAIT_ACC) || (state == ST_WAIT_DONE);

    // Counter restarts on every state change, so each wait phase gets its own budget.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 16'd0;
        end else if (state_nxt != state) begin
            wait_cnt <= 16'd0;
        end else if (in_wait) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = in_wait && (wait_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (timeout_hit && (state_nxt == ST_RELEASE)
                     && !((state == ST_WAIT_DONE) && tx_idle)) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TCYC = 16'd20;
`else
    localparam logic [15:0] TCYC = 16'd50000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_idle;
    logic        busy;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic        err;
`endif

    logic model_en;
    logic model_idle;
    logic forced_idle;

    assign tx_idle = model_en ? model_idle : forced_idle;

    uart_tx_arbiter #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_idle  (tx_idle),
        .busy     (busy)
`ifdef UART_TX_ARB_TIMEOUT_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        bit         acks;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] ack_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         rise_cyc = -100;
    logic       prev_idle = 1'b1;
    exp_t       mon_e;
    logic [3:0] mon_g;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within bound", name);
    endfunction

    // Transmitter model: drops idle one cycle after tx_start, busy for 10 cycles.
    initial begin
        model_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start && model_en) begin
                @(posedge clk);
                #1 model_idle = 1'b0;
                repeat (10) @(posedge clk);
                #1 model_idle = 1'b1;
            end
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (tx_idle && !prev_idle) rise_cyc = cyc;
        prev_idle = tx_idle;
        if (tx_start) begin
            start_cnt++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_tx_start");
            end else begin
                mon_e = exp_q.pop_front();
                check("start_grant", 32'(grant), 32'(mon_e.g));
                check("start_data", 32'(tx_data), 32'(mon_e.d));
                if (mon_e.acks) ack_q.push_back(mon_e.g);
            end
        end
        if (ack != 4'b0000) begin
            if (ack_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got %0h expected none", ack);
            end else begin
                mon_g = ack_q.pop_front();
                check("ack_value", 32'(ack), 32'(mon_g));
                check("ack_latency", 32'(cyc), 32'(rise_cyc + 1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(logic [3:0] g, logic [7:0] d, bit acks);
        exp_t e;
        e.g = g;
        e.d = d;
        e.acks = acks;
        exp_q.push_back(e);
    endtask

    task automatic wait_start(string name, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tx_start) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now(name);
    endtask

    task automatic wait_ack(string name, output int idx);
        idx = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ack != 4'b0000) begin
                for (int b = 0; b < 4; b++) if (ack[b]) idx = b;
                break;
            end
        end
        if (idx < 0) fail_now(name);
    endtask

    task automatic wait_idle_level(string name, logic lvl);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (tx_idle == lvl) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now(name);
    endtask

    task automatic wait_grant_zero(string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (grant == 4'b0000) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now(name);
    endtask

    initial begin
        int c0;
        int at;
        int idx;
        int s0;
        rst_n       = 1'b0;
        req         = 4'b0000;
        req_data    = 32'h0;
        model_en    = 1'b1;
        forced_idle = 1'b1;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("rst_err", 32'(err), 32'h0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Single request, byte 4B, tx_start two cycles after req rises
        push(4'b0001, 8'h4B, 1'b1);
        req_data[7:0] = 8'h4B;
        req = 4'b0001;
        c0 = cyc;
        wait_start("single_start", at);
        check("single_latency", 32'(at), 32'(c0 + 2));
        check("single_busy", 32'(busy), 32'h1);
        wait_ack("single_ack", idx);
        check("single_ack_idx", 32'(idx), 32'h0);
        step();
        req = 4'b0000;
        repeat (2) step();

        // Round robin from reset pointer: 0,1,2,3,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_data = 32'hA3A2A1A0;
        push(4'b0001, 8'hA0, 1'b1);
        push(4'b0010, 8'hA1, 1'b1);
        push(4'b0100, 8'hA2, 1'b1);
        push(4'b1000, 8'hA3, 1'b1);
        push(4'b0001, 8'hB0, 1'b1);
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_ack("rr_ack", idx);
            if (idx < 0) break;
            step();
            if (f == 4) begin
                req = 4'b0000;
            end else begin
                req[idx] = 1'b0;
                step();
                req_data[8*idx +: 8] = 8'hB0 | 8'(idx);
                req[idx] = 1'b1;
            end
        end
        repeat (2) step();

        // Requester 2 drops req during WAIT_DONE; frame still completes
        push(4'b0100, 8'hC2, 1'b1);
        req_data[23:16] = 8'hC2;
        req = 4'b0100;
        wait_idle_level("drop_idle_low", 1'b0);
        step();
        req = 4'b0000;
        @(negedge clk);
        check("drop_grant_held", 32'(grant), 32'h4);
        wait_ack("drop_ack", idx);
        check("drop_ack_idx", 32'(idx), 32'h2);
        repeat (2) step();

        // Reset during WAIT_DONE: everything clears, no ack
        push(4'b0001, 8'hD0, 1'b0);
        req_data[7:0] = 8'hD0;
        req = 4'b0001;
        wait_idle_level("rstmid_idle_low", 1'b0);
        step();
        rst_n = 1'b0;
        req = 4'b0000;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_grant", 32'(grant), 32'h0);
        check("rstmid_ack", 32'(ack), 32'h0);
        check("rstmid_tx_start", 32'(tx_start), 32'h0);
        check("rstmid_tx_data", 32'(tx_data), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        wait_idle_level("rstmid_idle_back", 1'b1);
        repeat (2) step();

        // tx_idle held low: no start until it rises
        model_en = 1'b0;
        forced_idle = 1'b0;
        push(4'b0010, 8'hE1, 1'b1);
        req_data[15:8] = 8'hE1;
        req = 4'b0010;
        s0 = start_cnt;
        repeat (6) step();
        @(negedge clk);
        check("held_no_start", 32'(start_cnt), 32'(s0));
        check("held_not_busy", 32'(busy), 32'h0);
        step();
        model_en = 1'b1;
        c0 = cyc;
        wait_start("held_start", at);
        check("held_latency", 32'(at), 32'(c0 + 2));
        wait_ack("held_ack", idx);
        check("held_ack_idx", 32'(idx), 32'h1);
        step();
        req = 4'b0000;
        repeat (2) step();

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Transmitter never goes busy: timeout releases, sets err, serves next
        model_en = 1'b0;
        forced_idle = 1'b1;
        push(4'b0100, 8'hF2, 1'b0);
        push(4'b1000, 8'hF3, 1'b0);
        req_data[31:16] = 16'hF3F2;
        req = 4'b1100;
        wait_start("to_start", at);
        wait_grant_zero("to_release");
        check("to_release_cycle", 32'(cyc), 32'(at + 21));
        check("to_err", 32'(err), 32'h1);
        wait_start("to_next_start", at);
        step();
        req = 4'b0000;
        wait_grant_zero("to_release2");
        check("to_err_sticky", 32'(err), 32'h1);
        model_en = 1'b1;
        repeat (2) step();
`endif

        repeat (3) step();
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("ack_q_drained", 32'(ack_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 16'd50000, giving the maximum cycles to wait per transmitter phase.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: per-requester byte request, held high until ack.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*8 bits: byte i at [8i+7:8i], stable while req[i] is high.
REQ-007 The block SHALL have port ack, output, NUM_REQ bits: one-cycle one-hot pulse when the granted byte has finished transmitting.
REQ-008 The block SHALL have port grant, output, NUM_REQ bits: one-hot owner of the transmitter, all zero when idle.
REQ-009 The block SHALL have port tx_start, output, 1 bit: one-cycle start pulse to the byte transmitter.
REQ-010 The block SHALL have port tx_data, output, 8 bits: byte presented to the transmitter, registered.
REQ-011 The block SHALL have port tx_idle, input, 1 bit: transmitter idle/done flag, high when no frame is in progress.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port err, output, 1 bit: sticky timeout flag, present only under the configuration macro.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT_ACC, WAIT_DONE and RELEASE.
REQ-015 In IDLE with req nonzero and tx_idle high, the block SHALL select the winner round-robin, starting from the index after the last granted one, then latch grant and tx_data, and go to START; with tx_idle low it SHALL stay in IDLE.
REQ-016 In START, tx_start SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT_ACC.
REQ-017 In WAIT_ACC, tx_idle low SHALL move the FSM to WAIT_DONE; in WAIT_DONE, tx_idle high SHALL move it to RELEASE.
REQ-018 In RELEASE, ack SHALL equal grant for one cycle, the round-robin pointer SHALL update to the granted index, grant SHALL clear, and the FSM SHALL return to IDLE.
REQ-019 From req rising to tx_start, latency SHALL be 2 cycles when the block is idle; back-to-back requests SHALL have a minimum gap of 1 IDLE cycle between RELEASE and the next START.
REQ-020 req changes during START through RELEASE SHALL NOT alter grant or tx_data; deasserting a granted req early SHALL NOT abort the frame.
REQ-021 When requests arrive simultaneously, the block SHALL serve them in cyclic index order with no starvation: each requester waits at most NUM_REQ-1 frames.
REQ-022 The pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-023 While rst_n is low at a clock edge, the block SHALL set state to IDLE, grant=0, ack=0, tx_start=0, tx_data=8'h00, busy=0, err=0, and pointer=NUM_REQ-1, so requester 0 has first priority.
REQ-024 A reset during any state SHALL abort immediately with no ack issued; the next grant SHALL follow the rule in REQ-015.

Configuration
REQ-025 When UART_TX_ARB_TIMEOUT_EN is defined, a 16-bit counter SHALL clear on entry to WAIT_ACC and to WAIT_DONE and increment each cycle in those states; on reaching TIMEOUT_CYC the FSM SHALL go to RELEASE without pulsing ack and SHALL set err until reset.
REQ-026 When UART_TX_ARB_TIMEOUT_EN is not defined, the counter and the err port SHALL be absent, and the wait states SHALL wait indefinitely.

Structure
REQ-027 The FSM state encoding typedef and the default TIMEOUT_CYC constant SHALL reside in the shared package uart_pkg.
REQ-028 The round-robin winner selection SHALL be a combinational sub-module rr_pick (inputs req and pointer; outputs one-hot winner and its index).

Verification
REQ-029 With req=4'b0001, byte 8'h4B, and a model that drops tx_idle 1 cycle after tx_start for 10 cycles: tx_start at cycle 2, tx_data=8'h4B, and ack=4'b0001 one cycle after tx_idle rises.
REQ-030 With req=4'b1111 held and re-asserted after each ack: grant order SHALL be 0,1,2,3,0, each with its own byte.
REQ-031 With requester 2 active and req[2] deasserted in WAIT_DONE: the frame SHALL complete and ack[2] SHALL pulse.
REQ-032 With rst_n low for 1 cycle during WAIT_DONE: all outputs SHALL read zero the next cycle, with no ack.
REQ-033 With tx_idle held low and req=4'b0010: no tx_start SHALL be issued until tx_idle goes high.
REQ-034 With UART_TX_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=20, and tx_idle never dropping after tx_start: RELEASE SHALL be reached 20 cycles later, with err=1, no ack, and the next requester served.
